// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RV32I core:
// opcodes, FSM state encoding, datapath select encodings.
package rv_ctrl_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] I_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R,
    S_EXEC_I, S_ADDR, S_MEM_RD, S_WB_MEM,
    S_MEM_WR, S_WB_ALU, S_BRANCH, S_JAL,
    S_JALR_A, S_JALR_L, S_LUI, S_AUIPC,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    A_PC, A_RS1, A_OLDPC, A_ZERO
  } alu_a_e;

  typedef enum logic [1:0] {
    B_RS2, B_IMM, B_FOUR, B_RSVD
  } alu_b_e;

  typedef enum logic [1:0] {
    OP_ADD, OP_CMP, OP_FUNC, OP_RSVD
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALUOUT, WB_MDR, WB_PC, WB_RSVD
  } wb_sel_e;

  typedef struct packed {
    logic    pc_we;
    logic    pc_sel;
    logic    oldpc_we;
    logic    ir_we;
    logic    mem_req;
    logic    mem_we;
    logic    addr_sel;
    alu_a_e  alu_a_sel;
    alu_b_e  alu_b_sel;
    alu_op_e alu_op;
    logic    rf_we;
    wb_sel_e wb_sel;
    logic    retire;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_out_decode: state + mem_ready/br_taken -> datapath controls.
// Ports: state_i, mem_ready_i, br_taken_i in; ctrl_o bundle out.
module ctrl_out_decode
  import rv_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   br_taken_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.oldpc_we  = 1'b1;
        ctrl_o.alu_a_sel = A_PC;
        ctrl_o.alu_b_sel = B_FOUR;
        ctrl_o.ir_we     = mem_ready_i;
        ctrl_o.pc_we     = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_a_sel = A_OLDPC;
        ctrl_o.alu_b_sel = B_IMM;
      end
      S_EXEC_R: begin
        ctrl_o.alu_a_sel = A_RS1;
        ctrl_o.alu_b_sel = B_RS2;
        ctrl_o.alu_op    = OP_FUNC;
      end
      S_EXEC_I: begin
        ctrl_o.alu_a_sel = A_RS1;
        ctrl_o.alu_b_sel = B_IMM;
        ctrl_o.alu_op    = OP_FUNC;
      end
      S_LUI: begin
        ctrl_o.alu_a_sel = A_ZERO;
        ctrl_o.alu_b_sel = B_IMM;
      end
      S_AUIPC: begin
        ctrl_o.alu_a_sel = A_OLDPC;
        ctrl_o.alu_b_sel = B_IMM;
      end
      S_WB_ALU: begin
        ctrl_o.rf_we  = 1'b1;
        ctrl_o.wb_sel = WB_ALUOUT;
        ctrl_o.retire = 1'b1;
      end
      S_ADDR, S_JALR_A: begin
        ctrl_o.alu_a_sel = A_RS1;
        ctrl_o.alu_b_sel = B_IMM;
      end
      S_MEM_RD: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.addr_sel = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.rf_we  = 1'b1;
        ctrl_o.wb_sel = WB_MDR;
        ctrl_o.retire = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.mem_we   = 1'b1;
        ctrl_o.addr_sel = 1'b1;
        ctrl_o.retire   = mem_ready_i;
      end
      S_BRANCH: begin
        ctrl_o.alu_a_sel = A_RS1;
        ctrl_o.alu_b_sel = B_RS2;
        ctrl_o.alu_op    = OP_CMP;
        ctrl_o.pc_sel    = 1'b1;
        ctrl_o.pc_we     = br_taken_i;
        ctrl_o.retire    = 1'b1;
      end
      S_JAL, S_JALR_L: begin
        ctrl_o.rf_we  = 1'b1;
        ctrl_o.wb_sel = WB_PC;
        ctrl_o.pc_we  = 1'b1;
        ctrl_o.pc_sel = 1'b1;
        ctrl_o.retire = 1'b1;
      end
      S_TRAP: ctrl_o.illegal = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences one instruction at a time.
// In: clk, rst_n, opcode, br_taken, mem_ready. Out: datapath controls.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       oldpc_we,
  output logic       ir_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] alu_op,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          R_TYPE:         state_d = S_EXEC_R;
          I_TYPE:         state_d = S_EXEC_I;
          I_LOAD, S_TYPE: state_d = S_ADDR;
          B_TYPE:         state_d = S_BRANCH;
          JAL:            state_d = S_JAL;
          JALR:           state_d = S_JALR_A;
          LUI:            state_d = S_LUI;
          AUIPC:          state_d = S_AUIPC;
          default:        state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I,
      S_LUI, S_AUIPC: state_d = S_WB_ALU;
      // IR still holds the opcode: only loads/stores reach here
      S_ADDR: state_d = (opcode == I_LOAD) ? S_MEM_RD
                                          : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_JALR_A: state_d = S_JALR_L;
      S_WB_ALU, S_WB_MEM, S_BRANCH,
      S_JAL, S_JALR_L: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  ctrl_out_decode u_dec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .br_taken_i  (br_taken),
    .ctrl_o      (ctrl)
  );

  assign pc_we     = ctrl.pc_we;
  assign pc_sel    = ctrl.pc_sel;
  assign oldpc_we  = ctrl.oldpc_we;
  assign ir_we     = ctrl.ir_we;
  assign mem_req   = ctrl.mem_req;
  assign mem_we    = ctrl.mem_we;
  assign addr_sel  = ctrl.addr_sel;
  assign alu_a_sel = ctrl.alu_a_sel;
  assign alu_b_sel = ctrl.alu_b_sel;
  assign alu_op    = ctrl.alu_op;
  assign rf_we     = ctrl.rf_we;
  assign wb_sel    = ctrl.wb_sel;
  assign retire    = ctrl.retire;
  assign illegal   = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: cycle-by-cycle output vectors.
// Vector order: pc_we pc_sel oldpc ir mreq mwe asel a b op rf wb ret ill
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, pc_sel, oldpc_we, ir_we;
  logic       mem_req, mem_we, addr_sel;
  logic [1:0] alu_a_sel, alu_b_sel, alu_op, wb_sel;
  logic       rf_we, retire, illegal;
  logic [18:0] outs;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .br_taken  (br_taken),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .oldpc_we  (oldpc_we),
    .ir_we     (ir_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .retire    (retire),
    .illegal   (illegal)
  );

  assign outs = {pc_we, pc_sel, oldpc_we, ir_we,
                 mem_req, mem_we, addr_sel,
                 alu_a_sel, alu_b_sel, alu_op,
                 rf_we, wb_sel, retire, illegal};

  localparam logic [18:0] V_IDLE = 19'd0;
  localparam logic [18:0] V_FW = {4'b0010, 3'b100,
    2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_FR = {4'b1011, 3'b100,
    2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_DEC = {4'b0000, 3'b000,
    2'd2, 2'd1, 2'd0, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_EXR = {4'b0000, 3'b000,
    2'd1, 2'd0, 2'd2, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_EXI = {4'b0000, 3'b000,
    2'd1, 2'd1, 2'd2, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_LUI = {4'b0000, 3'b000,
    2'd3, 2'd1, 2'd0, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_AUI = {4'b0000, 3'b000,
    2'd2, 2'd1, 2'd0, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_WBA = {4'b0000, 3'b000,
    2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'b10};
  localparam logic [18:0] V_ADR = {4'b0000, 3'b000,
    2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_MRD = {4'b0000, 3'b101,
    2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_WBM = {4'b0000, 3'b000,
    2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 2'b10};
  localparam logic [18:0] V_MWW = {4'b0000, 3'b111,
    2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'b00};
  localparam logic [18:0] V_MWR = {4'b0000, 3'b111,
    2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'b10};
  localparam logic [18:0] V_BNT = {4'b0100, 3'b000,
    2'd1, 2'd0, 2'd1, 1'b0, 2'd0, 2'b10};
  localparam logic [18:0] V_BT = {4'b1100, 3'b000,
    2'd1, 2'd0, 2'd1, 1'b0, 2'd0, 2'b10};
  localparam logic [18:0] V_JMP = {4'b1100, 3'b000,
    2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 2'b10};
  localparam logic [18:0] V_TRP = {4'b0000, 3'b000,
    2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'b01};

  task automatic check(input string tag,
                       input logic [18:0] got,
                       input logic [18:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic rdy,
                     input logic bt, input logic [18:0] exp);
    mem_ready = rdy;
    br_taken  = bt;
    @(negedge clk);
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst1", 1'b1, 1'b1, V_IDLE);
    cyc("rst2", 1'b0, 1'b0, V_IDLE);
    rst_n = 1'b1;
    cyc("idle", 1'b1, 1'b0, V_IDLE);

    opcode = 7'b0110011;
    cyc("add_f",  1'b1, 1'b0, V_FR);
    cyc("add_d",  1'b1, 1'b1, V_DEC);
    cyc("add_x",  1'b1, 1'b0, V_EXR);
    cyc("add_wb", 1'b1, 1'b0, V_WBA);

    opcode = 7'b0000011;
    cyc("lw_fw",  1'b0, 1'b0, V_FW);
    cyc("lw_f",   1'b1, 1'b0, V_FR);
    cyc("lw_d",   1'b0, 1'b0, V_DEC);
    cyc("lw_a",   1'b1, 1'b0, V_ADR);
    cyc("lw_m0",  1'b0, 1'b0, V_MRD);
    cyc("lw_m1",  1'b0, 1'b0, V_MRD);
    cyc("lw_m2",  1'b1, 1'b0, V_MRD);
    cyc("lw_wb",  1'b0, 1'b0, V_WBM);

    opcode = 7'b1100011;
    cyc("b0_f",   1'b1, 1'b1, V_FR);
    cyc("b0_d",   1'b0, 1'b1, V_DEC);
    cyc("b0_br",  1'b0, 1'b0, V_BNT);
    cyc("b1_f",   1'b1, 1'b0, V_FR);
    cyc("b1_d",   1'b0, 1'b0, V_DEC);
    cyc("b1_br",  1'b0, 1'b1, V_BT);

    opcode = 7'b0010011;
    cyc("ai_f",   1'b1, 1'b0, V_FR);
    cyc("ai_d",   1'b0, 1'b0, V_DEC);
    cyc("ai_x",   1'b0, 1'b0, V_EXI);
    cyc("ai_wb",  1'b0, 1'b0, V_WBA);

    opcode = 7'b0110111;
    cyc("lui_f",  1'b1, 1'b0, V_FR);
    cyc("lui_d",  1'b0, 1'b0, V_DEC);
    cyc("lui_x",  1'b0, 1'b0, V_LUI);
    cyc("lui_wb", 1'b0, 1'b0, V_WBA);

    opcode = 7'b0010111;
    cyc("aui_f",  1'b1, 1'b0, V_FR);
    cyc("aui_d",  1'b0, 1'b0, V_DEC);
    cyc("aui_x",  1'b0, 1'b0, V_AUI);
    cyc("aui_wb", 1'b0, 1'b0, V_WBA);

    opcode = 7'b1101111;
    cyc("jal_f",  1'b1, 1'b0, V_FR);
    cyc("jal_d",  1'b0, 1'b0, V_DEC);
    cyc("jal_j",  1'b0, 1'b0, V_JMP);

    opcode = 7'b0100011;
    cyc("sw_f",   1'b1, 1'b0, V_FR);
    cyc("sw_d",   1'b0, 1'b0, V_DEC);
    cyc("sw_a",   1'b0, 1'b0, V_ADR);
    cyc("sw_w0",  1'b0, 1'b0, V_MWW);
    cyc("sw_w1",  1'b1, 1'b0, V_MWR);
    cyc("sw_b2b", 1'b1, 1'b0, V_FR);
    cyc("swx_d",  1'b0, 1'b0, V_DEC);
    cyc("swx_a",  1'b0, 1'b0, V_ADR);
    cyc("swx_w",  1'b0, 1'b0, V_MWW);
    rst_n = 1'b0;
    cyc("swx_rs", 1'b0, 1'b0, V_MWW);
    rst_n = 1'b1;
    cyc("swx_id", 1'b1, 1'b0, V_IDLE);
    cyc("swx_f",  1'b0, 1'b0, V_FW);

    opcode = 7'b1100111;
    cyc("jr_f",   1'b1, 1'b0, V_FR);
    cyc("jr_d",   1'b0, 1'b0, V_DEC);
    cyc("jr_a",   1'b0, 1'b0, V_ADR);
    cyc("jr_l",   1'b0, 1'b0, V_JMP);

    opcode = 7'b0000000;
    cyc("tr_f",   1'b1, 1'b0, V_FR);
    cyc("tr_d",   1'b0, 1'b0, V_DEC);
    for (int i = 0; i < 10; i++)
      cyc("trap", i[0], ~i[0], V_TRP);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
